aes_128_iter: RTL and testbench
===============================

// Module: aes_128_iter
// PURPOSE
// - Folded AES-128 encryption core: R rounds per clock on one datapath, replacing the 10-stage unrolled pipeline where area matters.
// - Valid/ready handshake on input and output, on-the-fly key expansion, per-block tag passthrough.
// - Sits between a block source (DMA/CTR sequencer) and a result sink; accepts a new key with every block.
// PARAMETERS
// - RPC    1  rounds per cycle; legal values 1, 2, 5; any other value is a $error at elaboration.
// - TAG_W  8  width of the opaque tag carried alongside each block; minimum 1.
// PORTS
// - clk        in   1      clock; all logic on posedge
// - rst        in   1      synchronous reset, active-high
// - in_valid   in   1      in_state/in_key/in_tag valid
// - in_ready   out  1      core can accept a block this cycle
// - in_state   in   128    plaintext, byte 0 = [127:120]
// - in_key     in   128    cipher key, same byte order
// - in_tag     in   TAG_W  user tag
// - out_valid  out  1      out_data/out_tag valid
// - out_ready  in   1      sink accepts the result this cycle
// - out_data   out  128    ciphertext
// - out_tag    out  TAG_W  tag of the block in out_data
// BEHAVIOUR
// - Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
// - Reset:
//   - FSM goes to IDLE; round counter = 0; out_valid = 0; out_data = 0; out_tag = 0.
//   - in_ready is 1 in the cycle after rst deasserts.
//   - rst overrides every other input in the same cycle.
//   - Reset mid-operation discards the block in flight and emits no output for it.
// - FSM states: IDLE, RUN, DONE.
//   - IDLE: in_ready = 1. When in_valid is high, accept: s <= in_state ^ in_key; k <= in_key; tag <= in_tag; rnd <= 0; go to RUN.
//   - RUN: each cycle apply RPC rounds to s and expand k RPC times, then rnd <= rnd + RPC.
//     - Round i (1..10) uses rcon[i] = 01,02,04,08,10,20,40,80,1b,36.
//     - Rounds 1..9: SubBytes, ShiftRows, MixColumns, AddRoundKey.
//     - Round 10: MixColumns omitted.
//     - When rnd + RPC == 10: load out_data and out_tag, set out_valid, go to DONE.
//     - in_ready = 0 in RUN.
//   - DONE: out_valid = 1; out_data and out_tag hold stable while out_ready is low.
//     - On out_ready: clear out_valid. If in_valid is also high, accept the new block in the same cycle and go to RUN; otherwise go to IDLE.
//     - in_ready = out_ready in DONE; this is the only combinational input-to-output path.
// - Latency:
//   - out_valid rises N = 10/RPC clocks after the accepting edge (N = 10, 5, 2).
//   - Sustained throughput is one block per N+1 clocks.
// - in_* are sampled only on the accepting edge; later changes do not affect the block in flight.
// - in_valid with in_ready low is ignored. The source holds its request until accepted.
// - All byte arithmetic is in GF(2^8), polynomial 0x11b. The round counter is 4 bits and never exceeds 10.
// STRUCTURE
// - Package aes_pkg:
//   - sbox function and 256-entry table
//   - xtime and mix_column functions
//   - rcon function indexed 1..10
//   - typedef state_t as logic [127:0]
//   - FSM enum aes_fsm_e
// - Sub-module aes_round_step (combinational): inputs s, k, round index (4 bits). Outputs next s and next k; MixColumns is bypassed when index == 10.
// - Instantiate aes_round_step RPC times in a generate chain, with round index rnd+1+j for stage j.
// TESTING
// - FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32. Check RPC=1, 2, 5 and latency 10, 5, 2.
// - FIPS-197 App.C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. Send with tag 0x5a -> out_tag 0x5a.
// - Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data/out_tag stable and in_ready=0 throughout. Release -> out_valid drops the next cycle.
// - Back-to-back: in_valid held high with App.B then App.C.1 and out_ready=1 -> both results in order, second out_valid exactly N+1 cycles after the first.
// - Reset mid-run: assert rst at cycle 3 of RUN -> out_valid never rises for that block. in_ready=1 after reset; a fresh App.B block then yields the correct result.
// - Input change: alter in_state/in_key one cycle after acceptance -> the result still matches the originally accepted vector.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared types and GF(2^8) helpers for the folded AES-128 encryption core.
//   state_t      128-bit AES state / round key, byte 0 = [127:120]
//   aes_fsm_e    control FSM encoding (IDLE, RUN, DONE)
//   sbox()       forward S-box lookup
//   xtime()      multiply by x (0x02) modulo 0x11b
//   mix_column() MixColumns on one 32-bit column (row 0 in [31:24])
//   rcon()       round constant for round index 1..10 (0 elsewhere)
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_fsm_e;

    localparam int unsigned N_ROUNDS = 10;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column matrix rows: {2 3 1 1}, {1 2 3 1}, {1 1 2 3}, {3 1 1 2}.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_step.sv
// -----------------------------------------------------------------------------
// aes_round_step
// One combinational AES-128 encryption round plus the matching key-schedule
// step. The round key for round i is derived from the previous round key,
// so k_next is both the AddRoundKey operand and the key handed to the next
// stage.
//   s        in   128  state entering the round
//   k        in   128  round key of the previous round (cipher key for round 1)
//   rnd_idx  in   4    round index 1..10; 10 bypasses MixColumns
//   s_next   out  128  state after the round
//   k_next   out  128  round key used by this round
// -----------------------------------------------------------------------------
module aes_round_step
    import aes_pkg::*;
(
    input  state_t     s,
    input  state_t     k,
    input  logic [3:0] rnd_idx,
    output state_t     s_next,
    output state_t     k_next
);

    logic [31:0] key_temp;
    state_t      sub_shift;
    state_t      mixed;

    // Key expansion: temp = SubWord(RotWord(w3)) ^ {rcon, 0, 0, 0}.
    always_comb begin
        key_temp = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])}
                   ^ {rcon(rnd_idx), 24'h000000};
        k_next[127:96] = k[127:96] ^ key_temp;
        k_next[95:64]  = k[95:64]  ^ k_next[127:96];
        k_next[63:32]  = k[63:32]  ^ k_next[95:64];
        k_next[31:0]   = k[31:0]   ^ k_next[63:32];
    end

    // SubBytes and ShiftRows fused: byte (row r, column c) takes the
    // substituted byte from column (c + r) mod 4 of the same row.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        sub_shift = '0;
        mixed     = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_shift[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = mix_column(sub_shift[127 - 32*c -: 32]);
        end
    end

    assign s_next = ((rnd_idx == 4'd10) ? sub_shift : mixed) ^ k_next;

endmodule

// File: rtl/aes_128_iter.sv
// -----------------------------------------------------------------------------
// aes_128_iter
// Folded AES-128 encryption core. RPC rounds are evaluated per clock on a
// chain of aes_round_step instances; a block takes N = 10/RPC clocks from the
// accepting edge to out_valid. The key is supplied with every block and
// expanded on the fly alongside the state.
//   clk        in   1      clock, posedge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      in_state/in_key/in_tag valid
//   in_ready   out  1      core accepts a block this cycle
//   in_state   in   128    plaintext, byte 0 = [127:120]
//   in_key     in   128    cipher key, same byte order
//   in_tag     in   TAG_W  opaque tag carried with the block
//   out_valid  out  1      out_data/out_tag valid
//   out_ready  in   1      sink takes the result this cycle
//   out_data   out  128    ciphertext
//   out_tag    out  TAG_W  tag of the block in out_data
// -----------------------------------------------------------------------------
module aes_128_iter
    import aes_pkg::*;
#(
    parameter int RPC   = 1,
    parameter int TAG_W = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_state,
    input  logic [127:0]     in_key,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [TAG_W-1:0] out_tag
);

    if (RPC != 1 && RPC != 2 && RPC != 5) begin : g_bad_rpc
        $error("aes_128_iter: RPC must be 1, 2 or 5 (got %0d)", RPC);
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("aes_128_iter: TAG_W must be at least 1 (got %0d)", TAG_W);
    end

    localparam logic [3:0] RPC4  = 4'(RPC);
    localparam logic [3:0] LAST  = 4'(N_ROUNDS);

    aes_fsm_e         state_q, state_d;
    logic [3:0]       rnd_q;
    state_t           s_q;
    state_t           k_q;
    logic [TAG_W-1:0] tag_q;

    logic accept;
    logic finish;
    logic last_step;

    // Round chain: stage j applies round rnd_q + 1 + j.
    state_t s_chain [RPC+1];
    state_t k_chain [RPC+1];

    assign s_chain[0] = s_q;
    assign k_chain[0] = k_q;

    for (genvar j = 0; j < RPC; j++) begin : g_round
        aes_round_step u_step (
            .s       (s_chain[j]),
            .k       (k_chain[j]),
            .rnd_idx (rnd_q + 4'(j + 1)),
            .s_next  (s_chain[j+1]),
            .k_next  (k_chain[j+1])
        );
    end

    assign last_step = (rnd_q + RPC4 == LAST);
    assign out_valid = (state_q == DONE);

    // Next state and handshake. In DONE a new block can be taken in the
    // same cycle the result is drained, which is the only path from an
    // input (out_ready) to an output (in_ready).
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            rnd_q    <= 4'd0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rnd_q <= 4'd0;
            end else if (state_q == RUN) begin
                rnd_q <= rnd_q + RPC4;
            end
            if (finish) begin
                out_data <= s_chain[RPC];
                out_tag  <= tag_q;
            end
        end
    end

    // Working state, round key and tag.
    // NOTE: these datapath registers are deliberately not reset; they are always loaded on acceptance before being used.
    always_ff @(posedge clk) begin
        if (accept) begin
            s_q   <= in_state ^ in_key;
            k_q   <= in_key;
            tag_q <= in_tag;
        end else if (state_q == RUN) begin
            s_q <= s_chain[RPC];
            k_q <= k_chain[RPC];
        end
    end

endmodule

// File: tb/tb_aes_128_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_128_iter
// Directed bench for aes_128_iter using FIPS-197 known-answer vectors.
// The main instance uses RPC=1; two extra instances (RPC=2, RPC=5) confirm
// latency and result for the folded variants.
// -----------------------------------------------------------------------------
module tb_aes_128_iter;

    localparam int TAG_W = 8;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_state;
    logic [127:0]     in_key;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    logic             aux_valid;
    logic             aux_ready;
    logic             a2_in_ready, a5_in_ready;
    logic             a2_valid, a5_valid;
    logic [127:0]     a2_data, a5_data;
    logic [TAG_W-1:0] a2_tag, a5_tag;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    aes_128_iter #(.RPC(1), .TAG_W(TAG_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    aes_128_iter #(.RPC(2), .TAG_W(TAG_W)) u_rpc2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (aux_valid),
        .in_ready  (a2_in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_tag    (in_tag),
        .out_valid (a2_valid),
        .out_ready (aux_ready),
        .out_data  (a2_data),
        .out_tag   (a2_tag)
    );

    aes_128_iter #(.RPC(5), .TAG_W(TAG_W)) u_rpc5 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (aux_valid),
        .in_ready  (a5_in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_tag    (in_tag),
        .out_valid (a5_valid),
        .out_ready (aux_ready),
        .out_data  (a5_data),
        .out_tag   (a5_tag)
    );

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Present a block for one cycle on the main instance (which must be idle).
    // Returns at the falling edge right after the accepting edge.
    task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic [TAG_W-1:0] tag);
        in_state = pt;
        in_key   = key;
        in_tag   = tag;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count clock edges until out_valid, bounded by limit.
    task automatic wait_out(input int limit, output int lat);
        lat = 0;
        while (!out_valid && lat < limit) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, gap, lat2, lat5;
        logic seen;
        logic [127:0] d2, d5;
        logic [TAG_W-1:0] t2, t5;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_key    = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        aux_valid = 1'b0;
        aux_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 128'h0);
        check("rst_out_tag", out_tag, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1'b1);

        // App.B on RPC=1, then backpressure for 20 cycles.
        send(PT_B, KEY_B, 8'h11);
        check("run_in_ready_low", in_ready, 1'b0);
        wait_out(40, lat);
        check("b_latency", lat, 10);
        check("b_data", out_data, CT_B);
        check("b_tag", out_tag, 8'h11);
        in_state = PT_C;
        in_key   = KEY_C;
        in_tag   = 8'h99;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_data", out_data, CT_B);
            check("bp_out_tag", out_tag, 8'h11);
            check("bp_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", out_valid, 1'b0);
        check("bp_release_in_ready", in_ready, 1'b1);

        // App.C.1 with tag 0x5a; inputs altered right after acceptance.
        send(PT_C, KEY_C, 8'h5a);
        in_state = ~PT_C;
        in_key   = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        in_tag   = 8'hff;
        wait_out(40, lat);
        check("c_latency", lat, 10);
        check("c_data", out_data, CT_C);
        check("c_tag", out_tag, 8'h5a);
        @(negedge clk);
        check("c_drained", out_valid, 1'b0);

        // Back-to-back: in_valid held, App.B then App.C.1.
        in_state = PT_B;
        in_key   = KEY_B;
        in_tag   = 8'h21;
        in_valid = 1'b1;
        @(negedge clk);
        in_state = PT_C;
        in_key   = KEY_C;
        in_tag   = 8'h22;
        wait_out(40, lat);
        check("b2b_first_latency", lat, 10);
        check("b2b_first_data", out_data, CT_B);
        check("b2b_first_tag", out_tag, 8'h21);
        check("b2b_done_in_ready", in_ready, 1'b1);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (gap == 1) in_valid = 1'b0;
        end while (!out_valid && gap < 40);
        check("b2b_gap", gap, 11);
        check("b2b_second_data", out_data, CT_C);
        check("b2b_second_tag", out_tag, 8'h22);
        @(negedge clk);
        check("b2b_drained", out_valid, 1'b0);

        // Reset in the third RUN cycle discards the block.
        send(PT_B, KEY_B, 8'h33);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_output", seen, 1'b0);
        send(PT_B, KEY_B, 8'h44);
        wait_out(40, lat);
        check("post_rst_latency", lat, 10);
        check("post_rst_data", out_data, CT_B);
        check("post_rst_tag", out_tag, 8'h44);
        @(negedge clk);
        check("post_rst_drained", out_valid, 1'b0);

        // RPC=2 and RPC=5 instances on App.B.
        check("rpc2_in_ready", a2_in_ready, 1'b1);
        check("rpc5_in_ready", a5_in_ready, 1'b1);
        in_state  = PT_B;
        in_key    = KEY_B;
        in_tag    = 8'h55;
        aux_valid = 1'b1;
        @(negedge clk);
        aux_valid = 1'b0;
        lat2 = 0;
        lat5 = 0;
        d2   = '0;
        d5   = '0;
        t2   = '0;
        t5   = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (lat2 == 0 && a2_valid) begin
                lat2 = c;
                d2   = a2_data;
                t2   = a2_tag;
            end
            if (lat5 == 0 && a5_valid) begin
                lat5 = c;
                d5   = a5_data;
                t5   = a5_tag;
            end
        end
        check("rpc2_latency", lat2, 5);
        check("rpc2_data", d2, CT_B);
        check("rpc2_tag", t2, 8'h55);
        check("rpc5_latency", lat5, 2);
        check("rpc5_data", d5, CT_B);
        check("rpc5_tag", t5, 8'h55);
        aux_ready = 1'b1;
        @(negedge clk);
        check("rpc2_drained", a2_valid, 1'b0);
        check("rpc5_drained", a5_valid, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
